// File: rtl/trig_scheduler_pkg.sv
// Shared types and constants for the trigger scheduler: FSM states,
// source-ID width helper and the coincidence source numbering.
package trig_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT_ACK,
    S_HOLDOFF
  } state_t;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AND3_20 = 0;
  localparam int AND3_25 = 1;
  localparam int AND3_30 = 2;
  localparam int AND5_20 = 3;
  localparam int AND5_25 = 4;
  localparam int AND5_30 = 5;
  localparam int OR8_10  = 6;
  localparam int OR8_20  = 7;
  localparam int OR8_30  = 8;

endpackage

// File: rtl/trig_scheduler_if.sv
// Readout request channel: trigger pulse, tagged source ID, valid/ack handshake.
interface trig_scheduler_if #(
  parameter int NSRC = 9
);
  localparam int ID_W = trig_pkg::src_w(NSRC);

  logic            trig_out;
  logic [ID_W-1:0] trig_id;
  logic            trig_valid;
  logic            trig_ack;

  modport master (output trig_out, output trig_id, output trig_valid, input trig_ack);
  modport slave  (input trig_out, input trig_id, input trig_valid, output trig_ack);
endinterface

// File: rtl/trig_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter
  import trig_pkg::*;
#(
  parameter int NSRC = 9,
  parameter int ID_W = src_w(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NSRC-1:0] grant,
  output logic [ID_W-1:0] id
);
  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NSRC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/trig_scheduler.sv
// Trigger scheduler: edge detect, enable, prescale and pending latch per
// source, then round-robin grant into a pulse / readout handshake / holdoff.
module trig_scheduler
  import trig_pkg::*;
#(
  parameter int NSRC    = 9,
  parameter int PW      = 2,
  parameter int HOLDOFF = 8,
  parameter int PS_W    = 8,
  parameter int LOST_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      trig_in,
  input  logic [NSRC-1:0]      src_en,
  input  logic [NSRC*PS_W-1:0] prescale,
  trig_scheduler_if.master     rd,
  output logic                 busy,
  output logic [NSRC-1:0]      pending,
  output logic [LOST_W-1:0]    lost_cnt
);
  localparam int ID_W = src_w(NSRC);
  localparam int PW_W = src_w(PW);
  localparam int HO_W = src_w((HOLDOFF > 0) ? HOLDOFF : 1);

  logic [NSRC-1:0]   in_reg, prev_reg, edge_det, req;
  logic [NSRC-1:0]   pend_reg, pend_next, clr, grant;
  logic [ID_W-1:0]   gid, ptr_reg, id_reg;
  logic [LOST_W-1:0] lost_reg;
  logic              any_lost, out_reg, valid_reg;
  logic [PW_W-1:0]   pw_cnt_reg;
  logic [HO_W-1:0]   ho_cnt_reg;
  state_t            state_reg;

  // in_reg is the sampling stage for the asynchronous coincidence levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_reg   <= '0;
      prev_reg <= '0;
    end else begin
      in_reg   <= trig_in;
      prev_reg <= in_reg;
    end
  end

  assign edge_det = in_reg & ~prev_reg & src_en;

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_ps
      logic [PS_W-1:0] cnt_reg;
      logic [PS_W-1:0] p;
      assign p       = prescale[gi*PS_W +: PS_W];
      // >= so a counter left above a newly lowered P wraps and fires.
      assign req[gi] = edge_det[gi] && (cnt_reg >= p);
      always_ff @(posedge clk) begin
        if (rst)               cnt_reg <= '0;
        else if (edge_det[gi]) cnt_reg <= (cnt_reg >= p) ? '0 : cnt_reg + 1'b1;
      end
    end
  endgenerate

  rr_arbiter #(.NSRC(NSRC), .ID_W(ID_W)) u_arb (
    .req   (pend_reg),
    .ptr   (ptr_reg),
    .grant (grant),
    .id    (gid)
  );

  assign clr       = (state_reg == S_IDLE) ? grant : '0;
  assign pend_next = (pend_reg & ~clr) | req;
  assign any_lost  = |(req & pend_reg & ~clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
      lost_reg <= '0;
    end else begin
      pend_reg <= pend_next;
      if (any_lost && (lost_reg != {LOST_W{1'b1}})) lost_reg <= lost_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= '0;
      id_reg     <= '0;
      out_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      pw_cnt_reg <= '0;
      ho_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (|pend_reg) begin
            id_reg     <= gid;
            valid_reg  <= 1'b1;
            out_reg    <= 1'b1;
            pw_cnt_reg <= '0;
            ptr_reg    <= (gid == ID_W'(NSRC - 1)) ? '0 : gid + 1'b1;
            state_reg  <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (pw_cnt_reg == PW_W'(PW - 1)) begin
            out_reg   <= 1'b0;
            state_reg <= S_WAIT_ACK;
          end else begin
            pw_cnt_reg <= pw_cnt_reg + 1'b1;
          end
        end
        S_WAIT_ACK: begin
          if (rd.trig_ack) begin
            valid_reg  <= 1'b0;
            ho_cnt_reg <= '0;
            state_reg  <= (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (ho_cnt_reg == HO_W'(HOLDOFF - 1)) state_reg <= S_IDLE;
          else                                  ho_cnt_reg <= ho_cnt_reg + 1'b1;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign rd.trig_out   = out_reg;
  assign rd.trig_id    = id_reg;
  assign rd.trig_valid = valid_reg;
  assign busy          = (state_reg != S_IDLE);
  assign pending       = pend_reg;
  assign lost_cnt      = lost_reg;
endmodule

// File: tb/tb_trig_scheduler.sv
// Scoreboard bench for trig_scheduler: expected IDs queued at stimulus time,
// popped on each rising trig_valid.
module tb_trig_scheduler;
  import trig_pkg::*;

  localparam int NSRC    = 9;
  localparam int PW      = 2;
  localparam int HOLDOFF = 8;
  localparam int PS_W    = 8;
  localparam int LOST_W  = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NSRC-1:0]      trig_in = '0;
  logic [NSRC-1:0]      src_en = '1;
  logic [NSRC*PS_W-1:0] prescale = '0;
  logic                 busy;
  logic [NSRC-1:0]      pending;
  logic [LOST_W-1:0]    lost_cnt;

  trig_scheduler_if #(.NSRC(NSRC)) rd ();

  trig_scheduler #(
    .NSRC(NSRC), .PW(PW), .HOLDOFF(HOLDOFF), .PS_W(PS_W), .LOST_W(LOST_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .trig_in  (trig_in),
    .src_en   (src_en),
    .prescale (prescale),
    .rd       (rd.master),
    .busy     (busy),
    .pending  (pending),
    .lost_cnt (lost_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int trig_count = 0;
  bit ack_en = 1'b1;
  int ack_delay = 2;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ack responder: raises trig_ack once ack_delay WAIT_ACK cycles have been seen.
  initial begin
    int wcnt;
    wcnt = 0;
    rd.trig_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rd.trig_valid && !rd.trig_out) wcnt++;
      else wcnt = 0;
      rd.trig_ack = ack_en && (wcnt >= ack_delay);
    end
  end

  // Output monitor: scoreboard pop on rising trig_valid, pulse width on trig_out fall.
  initial begin
    bit pv, po;
    int width, e;
    pv = 0; po = 0; width = 0;
    forever begin
      @(negedge clk);
      if (rd.trig_valid && !pv) begin
        trig_count++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        $display("trig id=%0d exp=%0d out=%0b", rd.trig_id, e, rd.trig_out);
        check_val("trig_id", 32'(rd.trig_id), e);
        check_val("out_with_valid", 32'(rd.trig_out), 1);
      end
      if (rd.trig_out) width++;
      else begin
        if (po && rd.trig_valid) check_val("pulse_width", width, PW);
        width = 0;
      end
      pv = rd.trig_valid;
      po = rd.trig_out;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_src(input logic [NSRC-1:0] m);
    trig_in = trig_in | m;
    @(negedge clk);
    trig_in = trig_in & ~m;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while ((busy || pending != '0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(busy), 0);
  endtask

  task automatic wait_ack_state(input string tag);
    int n;
    n = 0;
    while (!(rd.trig_valid && !rd.trig_out) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(rd.trig_valid && !rd.trig_out), 1);
  endtask

  initial begin
    int bc, base;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_out", 32'(rd.trig_out), 0);
    check_val("rst_valid", 32'(rd.trig_valid), 0);
    check_val("rst_id", 32'(rd.trig_id), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_pend", 32'(pending), 0);
    check_val("rst_lost", 32'(lost_cnt), 0);

    // Single edge on source 4: 3-cycle latency, busy PW + ack wait + holdoff
    ack_delay = 2;
    exp_q.push_back(AND5_25);
    trig_in[4] = 1'b1;
    @(negedge clk);
    trig_in[4] = 1'b0;
    @(negedge clk);
    check_val("t1_pend", 32'(pending), 32'h010);
    check_val("t1_lat2", 32'(rd.trig_out), 0);
    @(negedge clk);
    check_val("t1_lat3", 32'(rd.trig_out), 1);
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    check_val("t1_busy_len", bc, PW + 2 + HOLDOFF);
    check_val("t1_lost", 32'(lost_cnt), 0);

    // Simultaneous 1,3,7 from pointer 0, then 0+8 shows pointer sits at 8
    do_reset();
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(7);
    pulse_src(9'b010001010);
    wait_idle("t2_idle_a");
    exp_q.push_back(8); exp_q.push_back(0);
    pulse_src(9'b100000001);
    wait_idle("t2_idle_b");
    check_val("t2_q", exp_q.size(), 0);
    check_val("t2_lost", 32'(lost_cnt), 0);

    // Prescale P=3 on source 2: fires on edges 4 and 8
    ack_delay = 1;
    prescale[2*PS_W +: PS_W] = 8'd3;
    base = trig_count;
    for (int i = 0; i < 10; i++) begin
      if ((i + 1) % 4 == 0) exp_q.push_back(2);
      pulse_src(9'b000000100);
      repeat (2) @(negedge clk);
    end
    wait_idle("t3_idle_a");
    check_val("t3_count", trig_count - base, 2);
    exp_q.push_back(2);
    for (int i = 0; i < 2; i++) begin
      pulse_src(9'b000000100);
      repeat (2) @(negedge clk);
    end
    wait_idle("t3_idle_b");
    check_val("t3_count_cnt2", trig_count - base, 3);

    // Edges on source 0 while WAIT_ACK held: one pending, two lost
    do_reset();
    prescale = '0;
    ack_en = 1'b0;
    exp_q.push_back(0);
    pulse_src(9'b000000001);
    wait_ack_state("t4_wait");
    repeat (3) pulse_src(9'b000000001);
    repeat (2) @(negedge clk);
    check_val("t4_pend", 32'(pending), 32'h001);
    check_val("t4_lost", 32'(lost_cnt), 2);
    exp_q.push_back(0);
    ack_en = 1'b1;
    wait_idle("t4_idle");
    check_val("t4_q", exp_q.size(), 0);
    check_val("t4_lost_after", 32'(lost_cnt), 2);

    // Disabled source 5, then enable while level already high
    src_en[5] = 1'b0;
    base = trig_count;
    repeat (2) pulse_src(9'b000100000);
    repeat (4) @(negedge clk);
    check_val("t5_pend_dis", 32'(pending), 0);
    trig_in[5] = 1'b1;
    repeat (3) @(negedge clk);
    src_en[5] = 1'b1;
    repeat (5) @(negedge clk);
    check_val("t5_pend_en", 32'(pending), 0);
    check_val("t5_count", trig_count - base, 0);
    trig_in[5] = 1'b0;
    @(negedge clk);
    exp_q.push_back(5);
    pulse_src(9'b000100000);
    wait_idle("t5_idle");
    check_val("t5_q", exp_q.size(), 0);

    // Reset during first PULSE cycle; pointer is 6 so source 2 wins over 3
    exp_q.push_back(2);
    pulse_src(9'b000001100);
    bc = 0;
    while (!rd.trig_out && bc < 50) begin
      @(negedge clk);
      bc++;
    end
    check_val("t6_pulse_seen", 32'(rd.trig_out), 1);
    check_val("t6_pend_pre", 32'(pending), 32'h008);
    rst = 1'b1;
    @(negedge clk);
    check_val("t6_out", 32'(rd.trig_out), 0);
    check_val("t6_valid", 32'(rd.trig_valid), 0);
    check_val("t6_pend", 32'(pending), 0);
    check_val("t6_lost", 32'(lost_cnt), 0);
    check_val("t6_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Lost counter saturation: sources 6/7 rise on alternate cycles, no ack
    ack_en = 1'b0;
    exp_q.push_back(6);
    for (int i = 0; i < (1 << LOST_W) + 40; i++) begin
      trig_in[6] = (i % 2 == 0);
      trig_in[7] = (i % 2 == 1);
      @(negedge clk);
    end
    trig_in = '0;
    repeat (2) @(negedge clk);
    check_val("t7_sat", 32'(lost_cnt), 32'(16'hFFFF));
    do_reset();
    ack_en = 1'b1;
    check_val("t7_lost_rst", 32'(lost_cnt), 0);
    check_val("t7_q", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trig_scheduler.md
Name: trig_scheduler

Overview:
- Sequences the scatter-trigger coincidence outputs: the 3/4- and 5/6-group ANDs at 20/25/30 ns widths, plus the 8-input OR tests.
- Each source passes through edge detect, enable mask and per-source prescaler into a pending latch.
- A round-robin arbiter grants one pending source at a time. The grant drives a fixed-width trigger pulse and a tagged source ID to the downstream readout, followed by an ack handshake and a holdoff window.
- Sits between the coincidence LUT outputs and the front-panel trigger output / readout request.

Parameters:
- NSRC, 9, number of trigger sources (bit i = source ID i).
- PW, 2, trig_out high time in clk cycles (≥1).
- HOLDOFF, 8, deadtime after ack in clk cycles (0 allowed = skip state).
- PS_W, 8, prescale counter width per source.
- LOST_W, 16, lost-trigger counter width.

Ports:
- clk  in  1  200 MHz system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- trig_in  in  NSRC  raw coincidence levels; unsynchronised pulses ≥1 cycle.
- src_en  in  NSRC  per-source enable; quasi-static.
- prescale  in  NSRC*PS_W  per-source value P; source i uses bits [i*PS_W +: PS_W]. Accepts 1 of every P+1 edges.
- trig_out  out  1  trigger pulse, PW cycles.
- trig_id  out  $clog2(NSRC)  granted source ID, valid while trig_valid.
- trig_valid  out  1  readout request.
- trig_ack  in  1  downstream accepts ID; sampled only in WAIT_ACK.
- busy  out  1  high in any state other than IDLE.
- pending  out  NSRC  current pending latch (status).
- lost_cnt  out  LOST_W  saturating count of dropped requests.

Behaviour:
- Reset: all outputs 0, prescale counters 0, previous-input register 0, RR pointer 0, FSM=IDLE. Reset mid-operation aborts immediately: no remaining pulse cycles, pending cleared.
- Edge detect: edge[i] = trig_in[i] & ~prev[i] & src_en[i]; prev is registered every cycle regardless of enable.
- Prescaler, per source, on edge:
  - if cnt==P: req[i]=1 and cnt←0;
  - else cnt←cnt+1, no req.
  - P=0 means every edge is accepted. Changing P takes effect at the next edge; if cnt>P, the next edge wraps cnt to 0 and fires.
- Pending latch: pend_next = (pend & ~clr) | req, where clr is the one-hot grant issued in IDLE.
  - lost_cnt += 1 (saturating at all-ones) when any bit has req & pend & ~clr; multiple same-cycle losses count as 1.
  - req on the source being cleared in the same cycle re-sets pend (set wins) and is not lost.
- Arbiter: round-robin starting at RR pointer. After a grant, the pointer ← granted ID + 1, wrapping NSRC-1 → 0.
- FSM:
  - IDLE: if |pend, grant → PULSE. trig_id and trig_valid register at the grant edge, so the first PULSE cycle has trig_out=1, trig_valid=1. Latency is edge on trig_in → trig_out high in 3 clk (prev reg, pend reg, grant reg).
  - PULSE: trig_out=1 for exactly PW cycles, then → WAIT_ACK. Ack during PULSE is ignored.
  - WAIT_ACK: trig_valid held, trig_id stable. On trig_ack: trig_valid←0, then → HOLDOFF (→ IDLE if HOLDOFF=0). No timeout.
  - HOLDOFF: count HOLDOFF cycles, then → IDLE. Requests keep latching as pending; at most one per source survives and the rest count as lost.
- trig_id is held at its last value when trig_valid=0.

Decomposition:
- Shared package trig_pkg:
  - state enum {IDLE, PULSE, WAIT_ACK, HOLDOFF};
  - SRC_ID width function;
  - source ID constants: AND3_20, AND3_25, AND3_30, AND5_20, AND5_25, AND5_30, OR8_10, OR8_20, OR8_30 = 0..8.
- Sub-module rr_arbiter (NSRC-wide req/pointer → one-hot grant + encoded ID, purely combinational). Instantiated once.
- Prescalers stay inline in a generate loop.

Test Plan:
- Single edge, source 4, P=0, ack 2 cycles after trig_valid, HOLDOFF=8 → trig_out high 2 cycles, 3 clk after edge, trig_id=4. busy stays high for PULSE+WAIT+8 cycles. lost_cnt=0.
- Sources 1, 3, 7 edge in the same cycle, RR pointer 0 → grants in order 1, 3, 7. Pointer ends at 8. All three trigger, lost_cnt=0.
- Source 2, P=3, 10 edges spaced 4 cycles apart, immediate ack → exactly 2 triggers (on edges 4 and 8), cnt=2 at end.
- Source 0 edges 3 times while WAIT_ACK is held (no ack) → pending[0]=1, lost_cnt=2. After ack and holdoff, one more trigger for ID 0.
- src_en[5]=0 with edges on trig_in[5] → no pending, no trigger. Set src_en[5]=1 while trig_in[5] is already high → no trigger until the next rising edge.
- Assert rst during PULSE cycle 1 → next cycle trig_out=0, trig_valid=0, pending=0, lost_cnt=0, FSM IDLE. lost_cnt saturation test: force 2^LOST_W+5 losses → holds all-ones.
